// File: rtl/mrna_iso_pkg.sv
// mrna_iso_pkg: shared types and constants for the mRNA isolation chip
// pneumatic sequencer.
//   - state_e            : protocol states with their 3-bit step codes
//   - V_*                : bit index of each air line within ctrl_out
//   - OPEN_*             : per-state sets of opened valves (1 = open)
//   - PUMP_PATTERN       : {pump1,pump2,pump3} per peristaltic phase, 1 = closed
//   - VALVES_ALL_CLOSED  : safe vector, every line pressurised
//   - valves_for()       : ctrl_out vector for a state and pump pattern
package mrna_iso_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_CELLS = 3'd1,
    S_LOAD_LYSIS = 3'd2,
    S_MIX        = 3'd3,
    S_BIND       = 3'd4,
    S_ELUTE      = 3'd5
  } state_e;

  localparam int unsigned NUM_VALVES = 13;

  localparam int unsigned V_CELLS_IN  = 0;
  localparam int unsigned V_CELLS_OUT = 1;
  localparam int unsigned V_LYSIS_IN  = 2;
  localparam int unsigned V_LYSIS_OUT = 3;
  localparam int unsigned V_PUSH      = 4;
  localparam int unsigned V_PUMP1     = 5;
  localparam int unsigned V_PUMP2     = 6;
  localparam int unsigned V_PUMP3     = 7;
  localparam int unsigned V_SEP       = 8;
  localparam int unsigned V_SIEVE     = 9;
  localparam int unsigned V_BEADS     = 10;
  localparam int unsigned V_WASTE     = 11;
  localparam int unsigned V_COLLECT   = 12;

  localparam logic [NUM_VALVES-1:0] VALVES_ALL_CLOSED = '1;

  localparam logic [NUM_VALVES-1:0] OPEN_LOAD_CELLS =
    (13'd1 << V_CELLS_IN) | (13'd1 << V_PUMP1) | (13'd1 << V_PUMP2) |
    (13'd1 << V_PUMP3)    | (13'd1 << V_LYSIS_OUT);
  localparam logic [NUM_VALVES-1:0] OPEN_LOAD_LYSIS =
    (13'd1 << V_LYSIS_IN) | (13'd1 << V_PUMP1) | (13'd1 << V_PUMP2) |
    (13'd1 << V_CELLS_OUT);
  localparam logic [NUM_VALVES-1:0] OPEN_BIND =
    (13'd1 << V_PUSH)  | (13'd1 << V_PUMP1) | (13'd1 << V_SEP) |
    (13'd1 << V_BEADS) | (13'd1 << V_SIEVE) | (13'd1 << V_WASTE);
  localparam logic [NUM_VALVES-1:0] OPEN_ELUTE =
    (13'd1 << V_PUSH)  | (13'd1 << V_PUMP1) | (13'd1 << V_SEP) |
    (13'd1 << V_SIEVE) | (13'd1 << V_COLLECT);

  // Entry [0] is phase P0; order P0..P5 = 110,100,101,001,011,010.
  localparam logic [5:0][2:0] PUMP_PATTERN =
    {3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};

  function automatic logic [NUM_VALVES-1:0] valves_for(input state_e s,
                                                       input logic [2:0] pat);
    logic [NUM_VALVES-1:0] v;
    v = VALVES_ALL_CLOSED;
    case (s)
      S_LOAD_CELLS: v = ~OPEN_LOAD_CELLS;
      S_LOAD_LYSIS: v = ~OPEN_LOAD_LYSIS;
      S_BIND:       v = ~OPEN_BIND;
      S_ELUTE:      v = ~OPEN_ELUTE;
      S_MIX: begin
        v[V_PUMP1] = pat[2];
        v[V_PUMP2] = pat[1];
        v[V_PUMP3] = pat[0];
      end
      default: v = VALVES_ALL_CLOSED;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mrna_iso_ctrl_pump.sv
// peristaltic_pump_seq: six-phase peristaltic pump sequencer.
//   clk, rst        : clock, asynchronous active-high reset
//   enable_i        : advance the phase timer this clock
//   clear_i         : return to P0 with timer and stroke count zeroed (wins)
//   pattern_o       : {pump1,pump2,pump3} of the phase in effect after the
//                     next edge, so the parent can register it with its state
//   stroke_done_o   : high during the last clock of P5 of each stroke
//   stroke_cnt_o    : strokes completed since the last clear
module peristaltic_pump_seq
  import mrna_iso_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        clear_i,
  output logic [2:0]  pattern_o,
  output logic        stroke_done_o,
  output logic [31:0] stroke_cnt_o
);

  logic [31:0] tmr_q, tmr_d;
  logic [31:0] strokes_q, strokes_d;
  logic [2:0]  phase_q, phase_d;
  logic        phase_last;

  assign phase_last    = enable_i && (tmr_q == 32'(STEP_CYCLES - 1));
  assign stroke_done_o = phase_last && (phase_q == 3'd5);
  assign stroke_cnt_o  = strokes_q;
  assign pattern_o     = PUMP_PATTERN[phase_d];

  always_comb begin
    tmr_d     = tmr_q;
    phase_d   = phase_q;
    strokes_d = strokes_q;
    if (clear_i) begin
      tmr_d     = '0;
      phase_d   = '0;
      strokes_d = '0;
    end else if (enable_i) begin
      if (phase_last) begin
        tmr_d = '0;
        if (phase_q == 3'd5) begin
          phase_d   = '0;
          strokes_d = strokes_q + 32'd1;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end else begin
        tmr_d = tmr_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q     <= '0;
      phase_q   <= '0;
      strokes_q <= '0;
    end else begin
      tmr_q     <= tmr_d;
      phase_q   <= phase_d;
      strokes_q <= strokes_d;
    end
  end

endmodule

// File: rtl/mrna_iso_ctrl.sv
// mrna_iso_ctrl: pneumatic protocol sequencer for the mRNA isolation chip.
// Protocol: IDLE -> LOAD_CELLS -> LOAD_LYSIS -> MIX -> BIND -> ELUTE -> IDLE.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin protocol (sampled only in IDLE)
//   abort     : safe stop from any state on the next edge
//   pause     : (only with MRNA_CTRL_PAUSE_EN) hold timers, close all valves
//   busy      : state is not IDLE
//   done      : one-cycle pulse on normal completion
//   step      : current state code
//   ctrl_out  : registered valve air lines, 1 = pressurised = closed
// Optional build macro: MRNA_CTRL_PAUSE_EN adds the pause input.
module mrna_iso_ctrl
  import mrna_iso_pkg::*;
#(
  parameter int unsigned STEP_CYCLES  = 1000,
  parameter int unsigned MIX_STROKES  = 64,
  parameter int unsigned LOAD_CYCLES  = 50000,
  parameter int unsigned BIND_CYCLES  = 100000,
  parameter int unsigned ELUTE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
`ifdef MRNA_CTRL_PAUSE_EN
  input  logic                  pause,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            step,
  output logic [NUM_VALVES-1:0] ctrl_out
);

  state_e                  state_q, state_d;
  logic [31:0]             tmr_q, tmr_d;
  logic [31:0]             tmr_limit;
  logic                    timed, expired;
  logic                    done_q, done_d;
  logic [NUM_VALVES-1:0]   ctrl_q, ctrl_d;
  logic                    paused;
  logic                    pump_en, pump_clr;
  logic [2:0]              pump_pat;
  logic                    stroke_done;
  logic [31:0]             stroke_cnt;

`ifdef MRNA_CTRL_PAUSE_EN
  assign paused = pause && (state_q != S_IDLE);
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    timed     = 1'b1;
    tmr_limit = '0;
    case (state_q)
      S_LOAD_CELLS, S_LOAD_LYSIS: tmr_limit = 32'(LOAD_CYCLES - 1);
      S_BIND:                     tmr_limit = 32'(BIND_CYCLES - 1);
      S_ELUTE:                    tmr_limit = 32'(ELUTE_CYCLES - 1);
      default:                    timed = 1'b0;
    endcase
  end

  assign expired = timed && (tmr_q == tmr_limit);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else if (!paused) begin
      case (state_q)
        S_IDLE:       if (start)   state_d = S_LOAD_CELLS;
        S_LOAD_CELLS: if (expired) state_d = S_LOAD_LYSIS;
        S_LOAD_LYSIS: if (expired) state_d = S_MIX;
        S_MIX: if (stroke_done && (stroke_cnt == 32'(MIX_STROKES - 1)))
                 state_d = S_BIND;
        S_BIND:       if (expired) state_d = S_ELUTE;
        S_ELUTE: if (expired) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // The pump sequencer is cleared on every state change so MIX always
  // starts at P0 with a fresh stroke count.
  assign pump_en  = (state_q == S_MIX) && !paused && !abort;
  assign pump_clr = abort || (state_d != state_q);

  always_comb begin
    tmr_d = tmr_q;
    if (pump_clr)
      tmr_d = '0;
    else if (timed && !paused)
      tmr_d = tmr_q + 32'd1;
  end

  // ctrl_out is registered from next-state values so that state, step and
  // valves all move on the same edge.
  always_comb begin
    ctrl_d = valves_for(state_d, pump_pat);
    if (paused && !abort)
      ctrl_d = VALVES_ALL_CLOSED;
  end

  peristaltic_pump_seq #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_pump (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (pump_en),
    .clear_i      (pump_clr),
    .pattern_o    (pump_pat),
    .stroke_done_o(stroke_done),
    .stroke_cnt_o (stroke_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      ctrl_q  <= VALVES_ALL_CLOSED;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign step     = state_q;
  assign ctrl_out = ctrl_q;

endmodule

// File: doc/mrna_iso_ctrl.md
Name: mrna_iso_ctrl

Overview:
Pneumatic control sequencer that drives the 13 air-control inputs of the mRNA isolation chip: cells, lysis, push, the pump1..3 triple, sep, sieve, beads, waste and collect.
- Runs a fixed protocol: load cells → load lysis buffer → peristaltic ring mix → bead bind/flush → elute to collect.
- Sits directly upstream of the chip netlist; each ctrl_out bit maps to one *_ctrl/pump input of the chip.
- Registered outputs; 1 = line pressurised = valve closed.

Parameters:
STEP_CYCLES, 1000, clocks per pump phase (≥1)
MIX_STROKES, 64, full 6-phase pump strokes in MIX (≥1)
LOAD_CYCLES, 50000, clocks spent in each of LOAD_CELLS and LOAD_LYSIS (≥1)
BIND_CYCLES, 100000, clocks in BIND (≥1)
ELUTE_CYCLES, 50000, clocks in ELUTE (≥1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin protocol; sampled only in IDLE
abort  in  1  immediate safe stop from any state
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
step  out  3  current state code
ctrl_out  out  13  valve air lines; bit map in package

Behaviour:
- Reset: state IDLE, ctrl_out = all 1 (every valve closed), busy=0, done=0, step=0, all counters 0.
- States and codes: IDLE=0, LOAD_CELLS=1, LOAD_LYSIS=2, MIX=3, BIND=4, ELUTE=5.
- Open sets per state; every bit not listed is 1:
  - IDLE: none.
  - LOAD_CELLS: cells_in, pump1, pump2, pump3, lysis_out.
  - LOAD_LYSIS: lysis_in, pump1, pump2, cells_out.
  - MIX: pump bits driven by the pump pattern; all other bits closed.
  - BIND: push, pump1, sep, beads, sieve, waste.
  - ELUTE: push, pump1, sep, sieve, collect.
- Sequence: IDLE --start--> LOAD_CELLS --LOAD_CYCLES--> LOAD_LYSIS --LOAD_CYCLES--> MIX --MIX_STROKES strokes--> BIND --BIND_CYCLES--> ELUTE --ELUTE_CYCLES--> IDLE.
- Timing:
  - State, step and ctrl_out all change on the same clk edge.
  - start high at edge k in IDLE gives LOAD_CELLS values visible after edge k; the state lasts exactly N clocks.
  - The ELUTE→IDLE edge asserts done for exactly one cycle.
- Pump pattern {pump1,pump2,pump3}, 1=closed, phases P0..P5 = 110,100,101,001,011,010.
  - Each phase lasts STEP_CYCLES clocks; one stroke = P0..P5.
  - The pattern starts at P0 on MIX entry. MIX exits after the last clock of P5 of stroke MIX_STROKES.
- abort:
  - Wins over start and over every timer expiry.
  - On the next edge: state IDLE, ctrl_out all 1, done=0, pump phase and counters cleared.
- start while busy is ignored. start and abort together in IDLE result in IDLE.
- rst asserted mid-protocol: outputs return to reset values asynchronously.
- Counters are 32-bit. They compare against (param−1) and clear on every state change, so no wrap occurs within a state.

Optional Feature:
MRNA_CTRL_PAUSE_EN.
- Defined: adds input pause (1 bit).
  - While pause=1 and busy, the state timer, phase timer and stroke count hold, and ctrl_out is forced all 1.
  - On pause release the saved valve pattern is restored on the next edge and counting resumes.
  - abort still acts while paused. pause in IDLE has no effect.
- Undefined: no pause port; timers never stall.

Decomposition:
- Package mrna_iso_pkg holds:
  - State enum and 3-bit codes.
  - Bit indices for the 13 ctrl lines: cells_in, cells_out, lysis_in, lysis_out, push, pump1, pump2, pump3, sep, sieve, beads, waste, collect.
  - Per-state open-mask constants, the 6-entry pump pattern table, and VALVES_ALL_CLOSED.
- One sub-module peristaltic_pump_seq:
  - Inputs: enable, clear.
  - Outputs: 3-bit pattern and stroke_done pulse.
  - Owns the phase timer, phase index and stroke counter; parameterised by STEP_CYCLES.

Test Plan:
- Reset check: assert rst mid-LOAD_LYSIS → ctrl_out=13'h1FFF, busy=0, step=0 immediately, before any clk edge.
- Full protocol, params 3/2/4/5/2 (STEP, STROKES, LOAD, BIND, ELUTE): pulse start → total busy time 4+4+36+5+2=51 clocks, then one done pulse; state durations match exactly.
- Pump pattern, STEP_CYCLES=3: MIX pump bits read 110×3, 100×3, 101×3, 001×3, 011×3, 010×3, and the sequence repeats once; stroke 2 ends on the MIX→BIND edge.
- Abort: abort on clock 2 of BIND → next edge IDLE, ctrl_out all 1, no done; a later start restarts at LOAD_CELLS with full LOAD_CYCLES.
- Ignored start: start re-pulsed during MIX, and start+abort together in IDLE → no state change, no done.
- Pause (MRNA_CTRL_PAUSE_EN defined): pause 10 clocks during MIX P2 → ctrl_out all 1 for those 10 clocks; after release the remaining P2 clocks complete and total MIX length grows by exactly 10.
